// File: rtl/vga_frame_decoder.sv
// Sink-side VGA stream decoder: rebuilds the raster position from sampled syncs, checks line
// and frame lengths against the configured timing, and reports the lit-pixel bounding box.
module vga_frame_decoder #(
   parameter int unsigned HActive = 800,
   parameter int unsigned HFp     = 56,
   parameter int unsigned HSync   = 120,
   parameter int unsigned HBp     = 64,
   parameter int unsigned VActive = 600,
   parameter int unsigned VFp     = 37,
   parameter int unsigned VSync   = 6,
   parameter int unsigned VBp     = 23,
   parameter bit          SyncPol = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        px_en_i,
   input  logic        hsync_i,
   input  logic        vsync_i,
   input  logic        px_i,
   output logic [10:0] x_o,
   output logic [10:0] y_o,
   output logic        active_o,
   output logic        locked_o,
   output logic        timing_err_o,
   output logic        frame_done_o,
   output logic        bbox_valid_o,
   output logic [10:0] bbox_x_min_o,
   output logic [10:0] bbox_x_max_o,
   output logic [10:0] bbox_y_min_o,
   output logic [10:0] bbox_y_max_o
);

   localparam int unsigned HTotal = HActive + HFp + HSync + HBp;
   localparam int unsigned VTotal = VActive + VFp + VSync + VBp;
   localparam logic [10:0] CntMax = 11'h7ff;
   localparam logic [10:0] HStart = 11'(HSync + HBp);
   localparam logic [10:0] HEnd   = 11'(HSync + HBp + HActive);
   localparam logic [10:0] VStart = 11'(VSync + VBp);
   localparam logic [10:0] VEnd   = 11'(VSync + VBp + VActive);
   localparam logic [10:0] HLast  = 11'(HTotal - 1);
   localparam logic [10:0] VLast  = 11'(VTotal - 1);

   typedef enum logic [1:0] {StSearch, StCheck, StLocked} state_e;

   state_e      state_q, state_d;
   logic        hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
   logic [10:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
   logic        line_err_q, line_err_d, first_q, first_d;
   logic [10:0] x_q, x_d, y_q, y_d;
   logic        active_q, active_d;
   logic        timing_err_q, timing_err_d, frame_done_q, frame_done_d;
   logic [10:0] acc_x_min_q, acc_x_min_d, acc_x_max_q, acc_x_max_d;
   logic [10:0] acc_y_min_q, acc_y_min_d, acc_y_max_q, acc_y_max_d;
   logic        hit_q, hit_d;
   logic [10:0] bbox_x_min_q, bbox_x_min_d, bbox_x_max_q, bbox_x_max_d;
   logic [10:0] bbox_y_min_q, bbox_y_min_d, bbox_y_max_q, bbox_y_max_d;
   logic        bbox_valid_q, bbox_valid_d;

   logic        hs_lvl, vs_lvl, hs_edge, vs_edge, in_active;
   logic [10:0] x_new, y_new;
   logic        line_chk, sat_err, line_err_now, frame_err;

   assign hs_lvl  = (hsync_i == SyncPol);
   assign vs_lvl  = (vsync_i == SyncPol);
   assign hs_edge = px_en_i && hs_lvl && !hs_prev_q;
   assign vs_edge = px_en_i && vs_lvl && !vs_prev_q;

   always_comb begin
      hs_prev_d = hs_prev_q;
      vs_prev_d = vs_prev_q;
      hcnt_d    = hcnt_q;
      vcnt_d    = vcnt_q;
      if (px_en_i) begin
         hs_prev_d = hs_lvl;
         vs_prev_d = vs_lvl;
         if (hs_edge) begin
            hcnt_d = '0;
         end else if (hcnt_q != CntMax) begin
            hcnt_d = hcnt_q + 11'd1;
         end
         // vsync clear takes priority over the line increment
         if (vs_edge) begin
            vcnt_d = '0;
         end else if (hs_edge && (vcnt_q != CntMax)) begin
            vcnt_d = vcnt_q + 11'd1;
         end
      end
   end

   // Position of the pixel sampled this cycle
   assign in_active = (hcnt_d >= HStart) && (hcnt_d < HEnd) &&
                      (vcnt_d >= VStart) && (vcnt_d < VEnd);
   assign x_new = hcnt_d - HStart;
   assign y_new = vcnt_d - VStart;

   always_comb begin
      x_d      = x_q;
      y_d      = y_q;
      active_d = active_q;
      if (px_en_i) begin
         active_d = in_active;
         if (in_active) begin
            x_d = x_new;
            y_d = y_new;
         end
      end
   end

   assign line_chk     = hs_edge && (hcnt_q != HLast) && !((state_q == StCheck) && first_q);
   assign sat_err      = px_en_i && ((hcnt_q == CntMax) || (vcnt_q == CntMax));
   assign line_err_now = (state_q != StSearch) && (line_chk || sat_err);
   assign frame_err    = vs_edge && (vcnt_q != VLast);

   always_comb begin
      state_d      = state_q;
      line_err_d   = line_err_q;
      first_d      = first_q;
      timing_err_d = 1'b0;
      frame_done_d = 1'b0;
      if (hs_edge && (state_q == StCheck)) begin
         first_d = 1'b0;
      end
      unique case (state_q)
         StSearch: begin
            if (vs_edge) begin
               state_d    = StCheck;
               line_err_d = 1'b0;
               first_d    = 1'b1;
            end
         end
         StCheck: begin
            if (vs_edge) begin
               if (!line_err_q && !line_err_now && !frame_err) begin
                  state_d = StLocked;
               end else begin
                  line_err_d = 1'b0;
                  first_d    = 1'b1;
               end
            end else if (line_err_now) begin
               line_err_d = 1'b1;
            end
         end
         StLocked: begin
            if (line_err_now || frame_err) begin
               state_d      = StSearch;
               timing_err_d = 1'b1;
            end else if (vs_edge) begin
               frame_done_d = 1'b1;
            end
         end
         default: state_d = StSearch;
      endcase
   end

   always_comb begin
      acc_x_min_d  = acc_x_min_q;
      acc_x_max_d  = acc_x_max_q;
      acc_y_min_d  = acc_y_min_q;
      acc_y_max_d  = acc_y_max_q;
      hit_d        = hit_q;
      bbox_x_min_d = bbox_x_min_q;
      bbox_x_max_d = bbox_x_max_q;
      bbox_y_min_d = bbox_y_min_q;
      bbox_y_max_d = bbox_y_max_q;
      bbox_valid_d = bbox_valid_q;
      if (vs_edge) begin
         bbox_x_min_d = acc_x_min_q;
         bbox_x_max_d = acc_x_max_q;
         bbox_y_min_d = acc_y_min_q;
         bbox_y_max_d = acc_y_max_q;
         bbox_valid_d = hit_q;
         acc_x_min_d  = CntMax;
         acc_x_max_d  = '0;
         acc_y_min_d  = CntMax;
         acc_y_max_d  = '0;
         hit_d        = 1'b0;
      end else if (px_en_i && in_active && px_i) begin
         if (x_new < acc_x_min_q) acc_x_min_d = x_new;
         if (x_new > acc_x_max_q) acc_x_max_d = x_new;
         if (y_new < acc_y_min_q) acc_y_min_d = y_new;
         if (y_new > acc_y_max_q) acc_y_max_d = y_new;
         hit_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StSearch;
         hs_prev_q    <= 1'b0;
         vs_prev_q    <= 1'b0;
         hcnt_q       <= '0;
         vcnt_q       <= '0;
         line_err_q   <= 1'b0;
         first_q      <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
         active_q     <= 1'b0;
         timing_err_q <= 1'b0;
         frame_done_q <= 1'b0;
         acc_x_min_q  <= CntMax;
         acc_x_max_q  <= '0;
         acc_y_min_q  <= CntMax;
         acc_y_max_q  <= '0;
         hit_q        <= 1'b0;
         bbox_x_min_q <= CntMax;
         bbox_x_max_q <= '0;
         bbox_y_min_q <= CntMax;
         bbox_y_max_q <= '0;
         bbox_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         hs_prev_q    <= hs_prev_d;
         vs_prev_q    <= vs_prev_d;
         hcnt_q       <= hcnt_d;
         vcnt_q       <= vcnt_d;
         line_err_q   <= line_err_d;
         first_q      <= first_d;
         x_q          <= x_d;
         y_q          <= y_d;
         active_q     <= active_d;
         timing_err_q <= timing_err_d;
         frame_done_q <= frame_done_d;
         acc_x_min_q  <= acc_x_min_d;
         acc_x_max_q  <= acc_x_max_d;
         acc_y_min_q  <= acc_y_min_d;
         acc_y_max_q  <= acc_y_max_d;
         hit_q        <= hit_d;
         bbox_x_min_q <= bbox_x_min_d;
         bbox_x_max_q <= bbox_x_max_d;
         bbox_y_min_q <= bbox_y_min_d;
         bbox_y_max_q <= bbox_y_max_d;
         bbox_valid_q <= bbox_valid_d;
      end
   end

   assign x_o          = x_q;
   assign y_o          = y_q;
   assign active_o     = active_q;
   assign locked_o     = (state_q == StLocked);
   assign timing_err_o = timing_err_q;
   assign frame_done_o = frame_done_q;
   assign bbox_valid_o = bbox_valid_q;
   assign bbox_x_min_o = bbox_x_min_q;
   assign bbox_x_max_o = bbox_x_max_q;
   assign bbox_y_min_o = bbox_y_min_q;
   assign bbox_y_max_o = bbox_y_max_q;

endmodule

// File: doc/vga_frame_decoder.md
# vga_frame_decoder

Sink-side decoder for the VGA stream produced by the game's pixel pipeline. It samples HSYNC/VSYNC and a 1-bit pixel on a pixel-rate strobe, rebuilds the x/y raster position, and checks line and frame lengths against the configured timing. It also reports the bounding box of lit pixels in each frame. It sits on the board-side loopback or bench path and lets a test or a self-check harness confirm ball and paddle placement from the video output alone.

## Interface
- H_ACTIVE, 800, visible pixels per line
- H_FP / H_SYNC / H_BP, 56 / 120 / 64, horizontal porch and sync widths in pixels; H_TOTAL = sum of the four horizontal values (1040)
- V_ACTIVE, 600, visible lines per frame
- V_FP / V_SYNC / V_BP, 37 / 6 / 23, vertical porch and sync widths in lines; V_TOTAL = 666
- SYNC_POL, 1, asserted level of hsync_in/vsync_in (1 = active-high)

- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- px_en  input  1  pixel strobe; all sampling and counting happens only on cycles where px_en=1
- hsync_in  input  1  horizontal sync
- vsync_in  input  1  vertical sync
- px_in  input  1  pixel lit flag
- x  output  11  active-area column of the last sampled pixel
- y  output  11  active-area row of the last sampled pixel
- active  output  1  last sampled pixel lies inside the active area
- locked  output  1  a full frame has matched the configured timing
- timing_err  output  1  one-clk pulse on a line or frame length mismatch while locked
- frame_done  output  1  one-clk pulse at the frame boundary while locked
- bbox_valid  output  1  the last completed frame contained at least one lit active pixel
- bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max  output  11 each  bounding box of the last completed frame

## Operation
- **Leading-edge detection.** A sync leading edge is a px_en sample at the asserted level when the previous px_en sample was deasserted. The previous-sample registers reset to deasserted.
- **hcnt (11 bits).**
  - Clears to 0 on the hsync leading-edge sample.
  - Otherwise increments and saturates at 2047.
- **vcnt (11 bits).**
  - Clears to 0 on the vsync leading-edge sample.
  - Otherwise increments on each hsync leading edge and saturates at 2047.
  - If both edges land on the same sample, the vsync clear wins.
- **Active area.**
  - active = 1 when H_SYNC+H_BP ≤ hcnt < H_SYNC+H_BP+H_ACTIVE and V_SYNC+V_BP ≤ vcnt < V_SYNC+V_BP+V_ACTIVE.
  - x = hcnt−(H_SYNC+H_BP) and y = vcnt−(V_SYNC+V_BP) while active.
  - x and y hold their last value while inactive.
- **Lock FSM.** States are SEARCH, CHECK and LOCKED; reset enters SEARCH.
  - SEARCH → CHECK on a vsync leading edge. The line-error flag clears on entry to CHECK.
  - Line check: on each hsync leading edge in CHECK or LOCKED, a previous hcnt ≠ H_TOTAL−1 is a line error. The first hsync edge after entering CHECK is exempt.
  - CHECK, on a vsync leading edge:
    - → LOCKED if there was no line error and vcnt = V_TOTAL−1 before the clear.
    - Otherwise → CHECK, restarting measurement. This is a new measurement window.
  - LOCKED: a line error, or a vsync edge with vcnt ≠ V_TOTAL−1, pulses timing_err and goes to SEARCH.
  - A saturated hcnt or vcnt while in CHECK or LOCKED is an error of the same kind.
  - locked = 1 only in LOCKED.
- **Bounding box.**
  - Accumulators reset to min = 2047, max = 0, hit = 0.
  - Every px_en sample with active=1 and px_in=1 updates min/max and sets hit. This happens in all states.
  - On each vsync leading edge:
    - Output registers load from the accumulators.
    - bbox_valid = hit.
    - Accumulators reinitialise.
    - frame_done pulses only if the FSM was in LOCKED before the edge and no error occurred on that edge.
  - When hit = 0, bbox outputs load 2047/0 unchanged and bbox_valid = 0.
- **Reset.** Asynchronous assertion mid-frame immediately forces all outputs to 0, except bbox_x_min and bbox_y_min, which go to 2047. The FSM returns to SEARCH.

## Timing
- All outputs are registered and update on the clk edge of the px_en cycle that sampled the inputs. Latency is one clk from the input sample to the visible output.
- Cycles with px_en=0 change nothing; the timing_err and frame_done pulses are exactly one clk wide.
- At nominal timing, the first frame_done comes at the third vsync leading edge after reset:
  - first edge: SEARCH → CHECK
  - second edge: CHECK → LOCKED
  - third edge: frame_done
- locked rises at the second vsync leading edge.

## Test plan
- **Nominal raster.** Run 3 frames at 1040×666, px_en every other clk, with a lit pixel at active (400,300). Required: locked rises at vsync edge 2; frame_done pulses at edge 3; bbox = x 400..400, y 300..300; bbox_valid = 1.
- **Coordinate alignment.** Sample at hcnt = 184 on vcnt = 29. Required: active = 1, x = 0, y = 0. At hcnt = 983: x = 799. At hcnt = 984: active = 0.
- **Short line while locked.** Make one line 1039 pixels. Required: timing_err pulses at the following hsync edge, locked drops to 0, no frame_done at the next vsync, and relock takes two more clean frames.
- **Empty frame.** Send a locked frame with no lit pixels. Required: frame_done pulses, bbox_valid = 0, min = 2047, max = 0.
- **Paddle rectangle.** Light x 10..15, y 250..349. Required: bbox = 10/15/250/349.
- **Mid-frame reset.** Assert rst low for 3 clk at vcnt = 200, then release. Required: all outputs at reset values immediately; no frame_done until the third vsync after release.
